// File: rtl/axi_lite_window_filter.sv
// AXI4-Lite address-window filter: forwards accesses that hit one of four peripheral windows, answers misses locally with DECERR.
// Optional downstream response timeout with drain enabled by defining AXI_LITE_WINDOW_FILTER_TIMEOUT_EN.
`timescale 1ns/1ps
module axi_lite_window_filter #(
  parameter logic [31:0] WIN0_ADDR      = 32'h9C400000,
  parameter logic [31:0] WIN1_ADDR      = 32'h9C420000,
  parameter logic [31:0] WIN2_ADDR      = 32'h99020000,
  parameter logic [31:0] WIN3_ADDR      = 32'h99040000,
  parameter int          WIN_SIZE_LOG2  = 16,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        axi_aclk,
  input  logic        axi_areset,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  output logic        decerr_pulse
);

  localparam logic [2:0] W_IDLE  = 3'd0;
  localparam logic [2:0] W_FWD   = 3'd1;
  localparam logic [2:0] W_BWAIT = 3'd2;
  localparam logic [2:0] W_BRESP = 3'd3;
  localparam logic [2:0] W_ERR   = 3'd4;
  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_FWD   = 3'd1;
  localparam logic [2:0] R_RWAIT = 3'd2;
  localparam logic [2:0] R_RRESP = 3'd3;
  localparam logic [2:0] R_ERR   = 3'd4;
`ifdef AXI_LITE_WINDOW_FILTER_TIMEOUT_EN
  localparam logic [2:0] W_DRAIN = 3'd5;
  localparam logic [2:0] R_DRAIN = 3'd5;
  localparam int         TO_W    = $clog2(TIMEOUT_CYCLES + 1);
`endif

  function automatic logic isHit(input logic [31:0] a);
    isHit = (a[31:WIN_SIZE_LOG2] == WIN0_ADDR[31:WIN_SIZE_LOG2]) |
            (a[31:WIN_SIZE_LOG2] == WIN1_ADDR[31:WIN_SIZE_LOG2]) |
            (a[31:WIN_SIZE_LOG2] == WIN2_ADDR[31:WIN_SIZE_LOG2]) |
            (a[31:WIN_SIZE_LOG2] == WIN3_ADDR[31:WIN_SIZE_LOG2]);
  endfunction

  logic [2:0]  wState_q, wState_d, rState_q, rState_d;
  logic        awReady_q, wReady_q, awGot_q, wGot_q, bValid_q, mBReady_q;
  logic        mAwValid_q, mWValid_q;
  logic [1:0]  bResp_q;
  logic [31:0] mAwAddr_q, mWData_q;
  logic [2:0]  mAwProt_q;
  logic [3:0]  mWStrb_q;
  logic        arReady_q, rValid_q, mArValid_q, mRReady_q;
  logic [31:0] rData_q, mArAddr_q;
  logic [1:0]  rResp_q;
  logic [2:0]  mArProt_q;
  logic        decerrPulse_q, decerrPulse_d;
  logic [1:0]  decerrCnt_q, decerrCnt_d;
  logic [2:0]  decerrPend;

  logic        awHs, wHs, wBothIn, wHit, awDone, wDone, wErrEnter;
  logic        arHs, rHit, rErrEnter;
  logic        wTimeout, rTimeout;

  assign awHs    = s_axi_awvalid & awReady_q;
  assign wHs     = s_axi_wvalid & wReady_q;
  assign wBothIn = (awGot_q | awHs) & (wGot_q | wHs);
  assign wHit    = isHit(awHs ? s_axi_awaddr : mAwAddr_q);
  assign awDone  = ~mAwValid_q | m_axi_awready;
  assign wDone   = ~mWValid_q | m_axi_wready;
  assign arHs    = s_axi_arvalid & arReady_q;
  assign rHit    = isHit(s_axi_araddr);

  assign wErrEnter = (wState_q == W_IDLE) & wBothIn & ~wHit;
  assign rErrEnter = (rState_q == R_IDLE) & arHs & ~rHit;

`ifdef AXI_LITE_WINDOW_FILTER_TIMEOUT_EN
  logic [TO_W-1:0] wCnt_q, rCnt_q;

  // Counters run only while a forwarded transaction awaits its downstream response.
  assign wTimeout = ((wState_q == W_FWD) | ((wState_q == W_BWAIT) & ~m_axi_bvalid)) &
                    (wCnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign rTimeout = ((rState_q == R_FWD) | ((rState_q == R_RWAIT) & ~m_axi_rvalid)) &
                    (rCnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wCnt_q <= '0;
      rCnt_q <= '0;
    end else begin
      wCnt_q <= ((wState_q == W_FWD) | (wState_q == W_BWAIT)) ? wCnt_q + TO_W'(1) : '0;
      rCnt_q <= ((rState_q == R_FWD) | (rState_q == R_RWAIT)) ? rCnt_q + TO_W'(1) : '0;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign wTimeout = 1'b0;
  assign rTimeout = 1'b0;
`endif

  always_comb begin
    wState_d = wState_q;
    case (wState_q)
      W_IDLE:  if (wBothIn) wState_d = wHit ? W_FWD : W_ERR;
      W_FWD:   if (awDone & wDone) wState_d = W_BWAIT;
      W_BWAIT: if (m_axi_bvalid) wState_d = W_BRESP;
      W_BRESP: if (s_axi_bready) wState_d = W_IDLE;
      W_ERR:   if (s_axi_bready) wState_d = W_IDLE;
`ifdef AXI_LITE_WINDOW_FILTER_TIMEOUT_EN
      W_DRAIN: if ((~mBReady_q | m_axi_bvalid) & (~bValid_q | s_axi_bready)) wState_d = W_IDLE;
`endif
      default: wState_d = W_IDLE;
    endcase
`ifdef AXI_LITE_WINDOW_FILTER_TIMEOUT_EN
    if (wTimeout) wState_d = W_DRAIN;
`endif
  end

  always_comb begin
    rState_d = rState_q;
    case (rState_q)
      R_IDLE:  if (arHs) rState_d = rHit ? R_FWD : R_ERR;
      R_FWD:   if (m_axi_arready) rState_d = R_RWAIT;
      R_RWAIT: if (m_axi_rvalid) rState_d = R_RRESP;
      R_RRESP: if (s_axi_rready) rState_d = R_IDLE;
      R_ERR:   if (s_axi_rready) rState_d = R_IDLE;
`ifdef AXI_LITE_WINDOW_FILTER_TIMEOUT_EN
      R_DRAIN: if ((~mRReady_q | m_axi_rvalid) & (~rValid_q | s_axi_rready)) rState_d = R_IDLE;
`endif
      default: rState_d = R_IDLE;
    endcase
`ifdef AXI_LITE_WINDOW_FILTER_TIMEOUT_EN
    if (rTimeout) rState_d = R_DRAIN;
`endif
  end

  // Both channels can miss on the same edge; queue the second pulse so each DECERR is seen separately.
  always_comb begin
    decerrPend    = {1'b0, decerrCnt_q} + {2'b0, wErrEnter} + {2'b0, rErrEnter};
    decerrPulse_d = 1'b0;
    if ((decerrPend != 3'd0) && !decerrPulse_q) begin
      decerrPulse_d = 1'b1;
      decerrPend    = decerrPend - 3'd1;
    end
    decerrCnt_d = decerrPend[1:0];
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wState_q   <= W_IDLE;
      awReady_q  <= 1'b0;
      wReady_q   <= 1'b0;
      awGot_q    <= 1'b0;
      wGot_q     <= 1'b0;
      bValid_q   <= 1'b0;
      bResp_q    <= 2'b00;
      mAwValid_q <= 1'b0;
      mWValid_q  <= 1'b0;
      mBReady_q  <= 1'b0;
      mAwAddr_q  <= '0;
      mAwProt_q  <= '0;
      mWData_q   <= '0;
      mWStrb_q   <= '0;
    end else begin
      wState_q <= wState_d;
      case (wState_q)
        W_IDLE: begin
          if (awHs) begin
            awGot_q   <= 1'b1;
            awReady_q <= 1'b0;
            mAwAddr_q <= s_axi_awaddr;
            mAwProt_q <= s_axi_awprot;
          end else if (!awGot_q) begin
            awReady_q <= 1'b1;
          end
          if (wHs) begin
            wGot_q   <= 1'b1;
            wReady_q <= 1'b0;
            mWData_q <= s_axi_wdata;
            mWStrb_q <= s_axi_wstrb;
          end else if (!wGot_q) begin
            wReady_q <= 1'b1;
          end
          if (wBothIn) begin
            awGot_q   <= 1'b0;
            wGot_q    <= 1'b0;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            if (wHit) begin
              mAwValid_q <= 1'b1;
              mWValid_q  <= 1'b1;
            end else begin
              bValid_q <= 1'b1;
              bResp_q  <= 2'b11;
            end
          end
        end
        W_FWD: begin
          if (m_axi_awready) mAwValid_q <= 1'b0;
          if (m_axi_wready) mWValid_q <= 1'b0;
          if (awDone & wDone) mBReady_q <= 1'b1;
        end
        W_BWAIT: begin
          if (m_axi_bvalid) begin
            mBReady_q <= 1'b0;
            bValid_q  <= 1'b1;
            bResp_q   <= m_axi_bresp;
          end
        end
        W_BRESP, W_ERR: begin
          if (s_axi_bready) bValid_q <= 1'b0;
        end
`ifdef AXI_LITE_WINDOW_FILTER_TIMEOUT_EN
        W_DRAIN: begin
          if (m_axi_bvalid) mBReady_q <= 1'b0;
          if (s_axi_bready) bValid_q <= 1'b0;
        end
`endif
        default: ;
      endcase
      if (wTimeout) begin
        mAwValid_q <= 1'b0;
        mWValid_q  <= 1'b0;
        mBReady_q  <= 1'b1;
        bValid_q   <= 1'b1;
        bResp_q    <= 2'b10;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rState_q      <= R_IDLE;
      arReady_q     <= 1'b0;
      rValid_q      <= 1'b0;
      rData_q       <= '0;
      rResp_q       <= 2'b00;
      mArValid_q    <= 1'b0;
      mRReady_q     <= 1'b0;
      mArAddr_q     <= '0;
      mArProt_q     <= '0;
      decerrPulse_q <= 1'b0;
      decerrCnt_q   <= '0;
    end else begin
      rState_q      <= rState_d;
      decerrPulse_q <= decerrPulse_d;
      decerrCnt_q   <= decerrCnt_d;
      case (rState_q)
        R_IDLE: begin
          arReady_q <= ~arHs;
          if (arHs) begin
            mArAddr_q <= s_axi_araddr;
            mArProt_q <= s_axi_arprot;
            if (rHit) begin
              mArValid_q <= 1'b1;
            end else begin
              rValid_q <= 1'b1;
              rData_q  <= '0;
              rResp_q  <= 2'b11;
            end
          end
        end
        R_FWD: begin
          if (m_axi_arready) begin
            mArValid_q <= 1'b0;
            mRReady_q  <= 1'b1;
          end
        end
        R_RWAIT: begin
          if (m_axi_rvalid) begin
            mRReady_q <= 1'b0;
            rValid_q  <= 1'b1;
            rData_q   <= m_axi_rdata;
            rResp_q   <= m_axi_rresp;
          end
        end
        R_RRESP, R_ERR: begin
          if (s_axi_rready) rValid_q <= 1'b0;
        end
`ifdef AXI_LITE_WINDOW_FILTER_TIMEOUT_EN
        R_DRAIN: begin
          if (m_axi_rvalid) mRReady_q <= 1'b0;
          if (s_axi_rready) rValid_q <= 1'b0;
        end
`endif
        default: ;
      endcase
      if (rTimeout) begin
        mArValid_q <= 1'b0;
        mRReady_q  <= 1'b1;
        rValid_q   <= 1'b1;
        rData_q    <= 32'hDEADDEAD;
        rResp_q    <= 2'b10;
      end
    end
  end

  assign s_axi_awready = awReady_q;
  assign s_axi_wready  = wReady_q;
  assign s_axi_bvalid  = bValid_q;
  assign s_axi_bresp   = bResp_q;
  assign s_axi_arready = arReady_q;
  assign s_axi_rvalid  = rValid_q;
  assign s_axi_rdata   = rData_q;
  assign s_axi_rresp   = rResp_q;
  assign m_axi_awvalid = mAwValid_q;
  assign m_axi_awaddr  = mAwAddr_q;
  assign m_axi_awprot  = mAwProt_q;
  assign m_axi_wvalid  = mWValid_q;
  assign m_axi_wdata   = mWData_q;
  assign m_axi_wstrb   = mWStrb_q;
  assign m_axi_bready  = mBReady_q;
  assign m_axi_arvalid = mArValid_q;
  assign m_axi_araddr  = mArAddr_q;
  assign m_axi_arprot  = mArProt_q;
  assign m_axi_rready  = mRReady_q;
  assign decerr_pulse  = decerrPulse_q;

endmodule

// File: doc/axi_lite_window_filter.md
Name: axi_lite_window_filter

Overview:
- AXI4-Lite slave stage that sits directly upstream of the dual-AD9361 PL wrapper's s_axi port, between the PS crossbar and the wrapper.
- Registers every transaction and forwards only those addresses that fall inside the four decoded peripheral windows (ADC DMA, DAC DMA, AD9361 core 0, AD9361 core 1).
- Out-of-window accesses are answered locally with DECERR and never reach the wrapper.
- Write and read channels are independent; each has at most one outstanding transaction.

Parameters:
- WIN0_ADDR, 32'h9C400000, base of window 0 (ADC DMA).
- WIN1_ADDR, 32'h9C420000, base of window 1 (DAC DMA).
- WIN2_ADDR, 32'h99020000, base of window 2 (AD9361 core 0).
- WIN3_ADDR, 32'h99040000, base of window 3 (AD9361 core 1).
- WIN_SIZE_LOG2, 16, log2 of window size in bytes; all windows are the same size and naturally aligned.
- TIMEOUT_CYCLES, 1024, downstream response timeout (used only with the optional feature).

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  synchronous reset, active-high.
- s_axi_aw{valid,ready,addr,prot}  in/out/in/in  1/1/32/3  upstream write address.
- s_axi_w{valid,ready,data,strb}  in/out/in/in  1/1/32/4  upstream write data.
- s_axi_b{valid,ready,resp}  out/in/out  1/1/2  upstream write response.
- s_axi_ar{valid,ready,addr,prot}  in/out/in/in  1/1/32/3  upstream read address.
- s_axi_r{valid,ready,data,resp}  out/in/out/out  1/1/32/2  upstream read data.
- m_axi_*  (mirror of every s_axi_* port, opposite direction, same widths)  downstream to the wrapper.
- decerr_pulse  out  1  one-cycle pulse per locally answered DECERR.

Behaviour:
- Hit test: hit = OR over the four windows of (addr[31:WIN_SIZE_LOG2] == WINn_ADDR[31:WIN_SIZE_LOG2]).
- All outputs are registered. Reset values: every valid = 0, every ready = 0, resp = 2'b00, data = 0, addr/prot/strb = 0, decerr_pulse = 0.
- Write FSM states: W_IDLE, W_FWD, W_BWAIT, W_BRESP, W_ERR.
  - W_IDLE: s_awready and s_wready are held 1 until the respective beat is captured, each dropped the cycle after its handshake. AW and W may arrive in either order or together.
  - When both are captured: hit goes to W_FWD; miss goes to W_ERR.
  - W_FWD: m_awvalid and m_wvalid rise the cycle after entry. Each drops independently on its own ready. Once both are done, go to W_BWAIT with m_bready = 1.
  - W_BWAIT: on m_bvalid, latch bresp, drop m_bready, go to W_BRESP.
  - W_BRESP: s_bvalid = 1 with the latched resp; hold until s_bready, then return to W_IDLE.
  - W_ERR: s_bvalid = 1, s_bresp = 2'b11, decerr_pulse for one cycle on entry; hold until s_bready, then W_IDLE.
- Read FSM states: R_IDLE, R_FWD, R_RWAIT, R_RRESP, R_ERR. These mirror the write FSM.
  - s_arready is 1 in R_IDLE.
  - R_ERR returns rdata = 32'h0 and rresp = 2'b11.
  - R_RRESP holds the latched rdata/rresp until s_rready.
- Latency for a hit with zero-wait downstream: AW/W handshake at cycle N, m_awvalid at N+1, earliest s_bvalid at N+3. Read follows the same timing.
- prot, strb, data and addr pass through unchanged. Address is not offset.
- Simultaneous read and write are processed concurrently with no arbitration.
- Upstream backpressure (s_bready/s_rready held low) stalls only its own FSM. Responses are never dropped.
- Reset mid-operation: all valids and readies are low on the first cycle after reset is asserted and the FSMs return to idle. In-flight transactions are abandoned.

Optional Feature:
- Macro AXI_LITE_WINDOW_FILTER_TIMEOUT_EN.
- When defined:
  - A per-channel counter starts on entry to W_FWD/R_FWD and clears on downstream response.
  - Reaching TIMEOUT_CYCLES returns SLVERR (2'b10) upstream with rdata = 32'hDEADDEAD.
  - The FSM then enters a drain state (W_DRAIN/R_DRAIN) that drops m_awvalid/m_wvalid/m_arvalid and holds m_bready/m_rready = 1 until a late response arrives; that response is discarded.
  - No new transaction is accepted on that channel until the drain completes.
- When undefined: no counter and no drain states; the FSM waits indefinitely.

Test Plan:
- Write 0x9C400010 data 0x12345678 strb 0xF, downstream BRESP OKAY after 0 waits -> m_awaddr = 0x9C400010, m_wdata = 0x12345678, s_bresp = 00, s_bvalid 3 cycles after the handshake.
- Read 0x99040004, downstream rdata 0xCAFEF00D, RRESP OKAY -> s_rdata = 0xCAFEF00D, s_rresp = 00, m_arvalid high exactly one handshake.
- Write 0x9C430000 (miss) -> no m_awvalid/m_wvalid, s_bresp = 11, decerr_pulse = 1 for 1 cycle. Read 0x00000000 -> s_rresp = 11, s_rdata = 0.
- W arrives 5 cycles before AW; s_bready held low 10 cycles -> single forwarded write; s_bvalid stays high and stable until s_bready.
- Concurrent read 0x99020000 and write 0x9C420008; assert axi_areset while m_bvalid is pending -> all valids = 0 on the next cycle; a subsequent clean write completes OKAY.
- With AXI_LITE_WINDOW_FILTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, downstream silent for 40 cycles -> s_rresp = 10, s_rdata = 0xDEADDEAD at cycle 16. A late m_rvalid is absorbed and does not reach upstream. s_arready stays 0 until the drain completes.
